seq_right_shifter: RTL and testbench

- Multi-cycle logical/arithmetic right shifter (SRL/SRA) for the MIPS ALU. It is the right-direction counterpart of the combinational left shifter (SLL, ctl 3'b011).
- It processes one shamt bit per cycle, LSB first: stage i shifts right by 2^i when shamt[i]=1. This trades combinational depth for a fixed latency.
- A start/busy/done handshake lets the EX-stage controller stall the pipeline while a shift is in flight.

---
 rtl/seq_right_shifter.sv | 136 +++++++++++++
 tb/tb_seq_right_shifter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_right_shifter.sv
// Multi-cycle SRL/SRA unit for the MIPS ALU: one shamt bit per cycle, LSB first,
// with a start/busy/done handshake so the EX stage can stall while a shift runs.
module seq_right_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       ctl,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int SW = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [2:0] CTL_SRL = 3'b100;
  localparam logic [2:0] CTL_SRA = 3'b101;
  localparam logic [SW-1:0] LAST_STAGE = SW'(SHW - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [SW-1:0]    stage_r, stage_s;
  logic [WIDTH-1:0] data_r,  data_s;
  logic [SHW-1:0]   sh_r,    sh_s;
  logic [2:0]       mode_r,  mode_s;
  logic [WIDTH-1:0] out_r,   out_s;
  logic             busy_r,  busy_s;
  logic             done_r,  done_s;
  logic [WIDTH-1:0] stepped_s;
  logic             arith_s;
  logic             supported_s;

  // Right shift by 2^idx; vacated MSBs take the current sign bit when arith is set.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic [SW-1:0]    idx,
    input logic             arith
  );
    logic [WIDTH-1:0] amt;
    logic [WIDTH-1:0] fill;
    amt  = WIDTH'(1) << idx;
    fill = arith ? {WIDTH{d[WIDTH-1]}} : {WIDTH{1'b0}};
    return (d >> amt) | (fill & ~({WIDTH{1'b1}} >> amt));
  endfunction

  // Decode the captured mode and compute this stage's data.
  always_comb begin
    arith_s     = (mode_r == CTL_SRA);
    supported_s = (mode_r == CTL_SRL) || (mode_r == CTL_SRA);
    if (sh_r[stage_r]) begin
      stepped_s = shift_stage(data_r, stage_r, arith_s);
    end else begin
      stepped_s = data_r;
    end
  end

  // Next-state and output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_s = state_r;
    stage_s = stage_r;
    data_s  = data_r;
    sh_s    = sh_r;
    mode_s  = mode_r;
    out_s   = out_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
          stage_s = {SW{1'b0}};
          data_s  = in;
          sh_s    = shamt;
          mode_s  = ctl;
          busy_s  = 1'b1;
        end else begin
          busy_s  = 1'b0;
        end
      end
      SHIFT: begin
        data_s = stepped_s;
        if (stage_r == LAST_STAGE) begin
          state_s = IDLE;
          stage_s = {SW{1'b0}};
          busy_s  = 1'b0;
          done_s  = 1'b1;
          // Unsupported operations still complete on time but yield zero.
          out_s   = supported_s ? stepped_s : {WIDTH{1'b0}};
        end else begin
          stage_s = stage_r + SW'(1);
          busy_s  = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        stage_s = {SW{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any in-flight operation and clears the result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      stage_r <= {SW{1'b0}};
      data_r  <= {WIDTH{1'b0}};
      sh_r    <= {SHW{1'b0}};
      mode_r  <= 3'b000;
      out_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      stage_r <= stage_s;
      data_r  <= data_s;
      sh_r    <= sh_s;
      mode_r  <= mode_s;
      out_r   <= out_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign out  = out_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Scoreboard-driven bench for seq_right_shifter: expected results are queued at
// issue time and compared when done pulses.
module tb_seq_right_shifter;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shamt;
  logic [2:0]       ctl;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  seq_right_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .shamt(shamt), .ctl(ctl),
    .out(out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                             input logic [SHW-1:0] s,
                                             input logic [2:0] c);
    logic signed [WIDTH-1:0] sa;
    sa = a;
    if (c == 3'b100) return a >> s;
    else if (c == 3'b101) return sa >>> s;
    else return '0;
  endfunction

  // Called at a negedge; leaves the bench at the negedge after the acceptance edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [SHW-1:0] s,
                       input logic [2:0] c, input bit push);
    in = a; shamt = s; ctl = c; start = 1'b1;
    if (push) exp_q.push_back(model(a, s, c));
    @(negedge clk);
    start = 1'b0;
    in = $urandom; shamt = 5'($urandom); ctl = 3'($urandom);
  endtask

  // Waits (bounded) for done; n = negedges waited, bc = busy samples seen before done.
  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n, bc;
    logic [WIDTH-1:0] e;
    rst = 1'b0; start = 1'b0; in = '0; shamt = '0; ctl = 3'b000;
    repeat (2) @(negedge clk);
    total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h want=%h", out, 32'h0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b1;
    @(negedge clk);
    issue(32'h80000000, 5'd31, 3'b100, 1'b1);
    wait_done(n, bc);
    total++; if (n !== 5) begin bad++; $display("FAIL reset_latency got=%0d want=5", n); end
    total++; if (bc !== 5) begin bad++; $display("FAIL reset_busy_cycles got=%0d want=5", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy_at_done got=%b want=0", busy); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    total++; if (out !== e || e !== 32'h00000001) begin bad++; $display("FAIL reset_first_out got=%h want=%h", out, 32'h00000001); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
  endtask

  task automatic test_sra();
    int n, bc;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] ins[2] = '{32'h80000000, 32'h7FFFFFF0};
    logic [WIDTH-1:0] want[2] = '{32'hF8000000, 32'h07FFFFFF};
    for (int i = 0; i < 2; i++) begin
      issue(ins[i], 5'd4, 3'b101, 1'b1);
      wait_done(n, bc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      total++; if (n !== 5 || out !== e || out !== want[i]) begin
        bad++; $display("FAIL sra_%0d got=%h lat=%0d want=%h lat=5", i, out, n, want[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_full();
    int n, bc;
    logic [WIDTH-1:0] e;
    issue(32'hDEADBEEF, 5'd0, 3'b100, 1'b1);
    wait_done(n, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    total++; if (n !== 5 || out !== e || out !== 32'hDEADBEEF) begin
      bad++; $display("FAIL zero_shift got=%h lat=%0d want=%h lat=5", out, n, 32'hDEADBEEF);
    end
    @(negedge clk);
    issue(32'hDEADBEEF, 5'd31, 3'b101, 1'b1);
    wait_done(n, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    total++; if (out !== e || out !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL full_sra got=%h want=%h", out, 32'hFFFFFFFF);
    end
    @(negedge clk);
  endtask

  task automatic test_unsupported();
    int n, bc;
    logic [WIDTH-1:0] e;
    issue(32'h12345678, 5'd3, 3'b011, 1'b1);
    wait_done(n, bc);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    total++; if (n !== 5 || bc !== 5) begin bad++; $display("FAIL unsup_timing got lat=%0d busy=%0d want 5/5", n, bc); end
    total++; if (out !== e || out !== 32'h0) begin bad++; $display("FAIL unsup_out got=%h want=%h", out, 32'h0); end
    @(negedge clk);
  endtask

  task automatic test_handshake();
    int n, bc;
    logic [WIDTH-1:0] e;
    issue(32'h0000F000, 5'd8, 3'b100, 1'b1);
    @(negedge clk);
    in = 32'hFFFFFFFF; shamt = 5'd0; ctl = 3'b100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    total++; if (n !== 3) begin bad++; $display("FAIL hs_latency got=%0d want=3", n); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    total++; if (out !== e || out !== 32'h000000F0) begin bad++; $display("FAIL hs_ignored got=%h want=%h", out, 32'h000000F0); end
    issue(32'h00000100, 5'd4, 3'b100, 1'b1);
    wait_done(n, bc);
    total++; if (n + 1 !== 6) begin bad++; $display("FAIL hs_b2b_gap got=%0d want=6", n + 1); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    total++; if (out !== e || out !== 32'h00000010) begin bad++; $display("FAIL hs_b2b_out got=%h want=%h", out, 32'h00000010); end
    n = 0;
    repeat (8) begin @(negedge clk); if (done) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL hs_extra_done got=%0d want=0", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(32'h80000000, 5'd1, 3'b101, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || out !== 32'h0) begin
      bad++; $display("FAIL midreset got busy=%b out=%h want busy=0 out=%h", busy, out, 32'h0);
    end
    rst = 1'b1;
    n = 0;
    repeat (10) begin @(negedge clk); if (done) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL midreset_done got=%0d want=0", n); end
  endtask

  task automatic test_back_to_back();
    int n, bc;
    logic [WIDTH-1:0] a, e, m;
    logic [SHW-1:0] s;
    logic [2:0] c;
    a = $urandom; s = 5'($urandom); c = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b101;
    issue(a, s, c, 1'b1);
    for (int i = 0; i < 8; i++) begin
      wait_done(n, bc);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      m = model(a, s, c);
      total++; if (n !== 5 || out !== e) begin
        bad++; $display("FAIL b2b_%0d got=%h lat=%0d want=%h (in=%h sh=%0d ctl=%b)", i, out, n, m, a, s, c);
      end
      a = $urandom; s = 5'($urandom); c = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b101;
      if (i < 7) issue(a, s, c, 1'b1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sra();
    test_zero_full();
    test_unsupported();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
